fpu_normalize_pack: RTL and testbench

- Back end of the floating-point adder datapath.
- Accepts the raw magnitude sum produced after operand swap, alignment and significand add/subtract.
- Normalizes it iteratively (one left shift per cycle), applies round-to-nearest-even, and packs an IEEE-754 single-precision word.
- Valid/ready handshake on both sides, so it can sit between the adder core and the FFT butterfly result registers.

---
 rtl/fpu_pkg.sv | 17 +
 rtl/fpu_round_rne.sv | 36 +++
 rtl/fpu_normalize_pack.sv | 140 ++++++++++++++
 tb/tb_fpu_normalize_pack.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared constants and state encoding for the FP adder back end
// (normalize, round-to-nearest-even, pack).
package fpu_pkg;

  localparam int               EXP_W     = 8;
  localparam logic [EXP_W-1:0] EXP_MAX   = 8'hFF;
  localparam int               SIG_W_DEF = 24;
  localparam int               FRAC_W    = SIG_W_DEF - 1;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    OUT
  } norm_state_t;

endpackage

// File: rtl/fpu_round_rne.sv
// Round-to-nearest-even on a packed {exp, frac} field.
// Any rounding carry ripples from the fraction into the exponent.
module fpu_round_rne
  import fpu_pkg::*;
#(
  parameter int FW = FRAC_W
) (
  input  logic [FW-1:0]    frac,
  input  logic [EXP_W-1:0] exp_field,
  input  logic             g,
  input  logic             r,
  input  logic             s,
  output logic [EXP_W-1:0] exp_out,
  output logic [FW-1:0]    frac_out,
  output logic             overflow
);

  localparam int SUM_W = EXP_W + FW + 1;

  logic             inc;
  logic [SUM_W-1:0] sum;

  // NOTE: every output gets a value on every path, so no latch is inferred.
  always_comb begin
    inc      = g & (r | s | frac[0]);
    sum      = {1'b0, exp_field, frac} + SUM_W'(inc);
    overflow = (sum[SUM_W-1:FW] >= {1'b0, EXP_MAX});
    exp_out  = sum[SUM_W-2:FW];
    frac_out = sum[FW-1:0];
    if (overflow) begin
      exp_out  = EXP_MAX;
      frac_out = '0;
    end
  end

endmodule

// File: rtl/fpu_normalize_pack.sv
// FP adder back end: carry adjust on capture, one left shift per cycle
// until normalized (or denormal), RNE rounding, then a held output beat.
module fpu_normalize_pack
  import fpu_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [SIG_W:0]   in_sum,
  input  logic [2:0]       in_grs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_overflow
);

  localparam int FW    = SIG_W - 1;
  localparam int CNT_W = $clog2(SIG_W);

  norm_state_t       state;
  logic              sign_q;
  logic [EXP_W-1:0]  exp_q;
  logic [SIG_W-1:0]  sig_q;
  logic              g_q, r_q, s_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       result_q;
  logic              ovf_q;

  logic [SIG_W-1:0]  cap_sig;
  logic [EXP_W-1:0]  cap_exp;
  logic              cap_g, cap_r, cap_s;
  logic              is_zero;
  logic              norm_done;
  logic [EXP_W-1:0]  exp_field;
  logic [EXP_W-1:0]  rnd_exp;
  logic [FW-1:0]     rnd_frac;
  logic              rnd_ovf;

  // A carry-out means the sum is one bit too wide: shift right into guard
  // and fold everything below guard into sticky.
  always_comb begin
    cap_sig = in_sum[SIG_W-1:0];
    cap_exp = in_exp;
    cap_g   = in_grs[2];
    cap_r   = in_grs[1];
    cap_s   = in_grs[0];
    if (in_sum[SIG_W]) begin
      cap_sig = in_sum[SIG_W:1];
      cap_exp = in_exp + 8'd1;
      cap_g   = in_sum[0];
      cap_r   = 1'b0;
      cap_s   = |in_grs;
    end
  end

  assign is_zero   = (sig_q == '0) && !(g_q | r_q | s_q);
  assign norm_done = is_zero || sig_q[SIG_W-1] || (exp_q <= 8'd1) ||
                     (cnt_q == CNT_W'(SIG_W - 1));
  // A cleared hidden bit after normalization means a denormal: field is 0.
  assign exp_field = sig_q[SIG_W-1] ? exp_q : '0;

  fpu_round_rne #(.FW(FW)) u_round (
    .frac      (sig_q[FW-1:0]),
    .exp_field (exp_field),
    .g         (g_q),
    .r         (r_q),
    .s         (s_q),
    .exp_out   (rnd_exp),
    .frac_out  (rnd_frac),
    .overflow  (rnd_ovf)
  );

  // NOTE: sequential state uses non-blocking assignments and clears on the
  // asynchronous reset, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      sig_q    <= '0;
      g_q      <= 1'b0;
      r_q      <= 1'b0;
      s_q      <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q <= in_sign;
            exp_q  <= cap_exp;
            sig_q  <= cap_sig;
            g_q    <= cap_g;
            r_q    <= cap_r;
            s_q    <= cap_s;
            cnt_q  <= '0;
            state  <= NORM;
          end
        end
        NORM: begin
          if (norm_done) begin
            state <= ROUND;
          end else begin
            sig_q <= {sig_q[SIG_W-2:0], g_q};
            g_q   <= r_q;
            r_q   <= 1'b0;
            exp_q <= exp_q - 8'd1;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ROUND: begin
          if (is_zero) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
          end else begin
            result_q <= {sign_q, rnd_exp, rnd_frac};
            ovf_q    <= rnd_ovf;
          end
          state <= OUT;
        end
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == OUT);
  assign out_result   = result_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_fpu_normalize_pack.sv
// Self-checking bench for fpu_normalize_pack: expectations are queued when an
// operation is driven and popped when the DUT presents its result.
module tb_fpu_normalize_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_sum;
  logic [2:0]  in_grs;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;

  always #5 clk = ~clk;

  fpu_normalize_pack #(.SIG_W(24)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_sum       (in_sum),
    .in_grs       (in_grs),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow)
  );

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } exp_t;

  typedef struct {
    logic        sign;
    logic [7:0]  e;
    logic [24:0] sum;
    logic [2:0]  grs;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } op_t;

  exp_t sb[$];
  op_t  tbl[13];
  int   n_vec = 0;
  int   n_err = 0;

  // Drive one beat at the falling edge; returns just after the accepting edge.
  task automatic drive_op(input op_t op);
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = op.sign;
    in_exp   = op.e;
    in_sum   = op.sum;
    in_grs   = op.grs;
    sb.push_back('{op.res, op.ovf, op.lat});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts rising edges from the accepting edge until out_valid is seen.
  task automatic wait_result(output logic found, output logic [31:0] res,
                             output logic ovf, output int lat);
    found = 1'b0;
    res   = '0;
    ovf   = 1'b0;
    lat   = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) begin
        found = 1'b1;
        res   = out_result;
        ovf   = out_overflow;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_sum    = '0;
    in_grs    = '0;
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
    n_vec++;
    if (out_result !== 32'h0 || out_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: result=%h ovf=%b, want 0/0", out_result, out_overflow);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic        found, ovf;
    logic [31:0] res;
    int          lat;
    exp_t        e;
    tbl = '{
      '{1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 1'b0, 2},
      '{1'b0, 8'd127, 25'h0000001, 3'b000, 32'h34000000, 1'b0, 25},
      '{1'b0, 8'd127, 25'h0FFFFFF, 3'b100, 32'h40000000, 1'b0, 2},
      '{1'b0, 8'd127, 25'h0FFFFFE, 3'b100, 32'h3FFFFFFE, 1'b0, 2},
      '{1'b0, 8'd254, 25'h1000000, 3'b000, 32'h7F800000, 1'b1, 2},
      '{1'b0, 8'd1,   25'h0400000, 3'b000, 32'h00400000, 1'b0, 2},
      '{1'b1, 8'd100, 25'h0000000, 3'b000, 32'h00000000, 1'b0, 2},
      '{1'b1, 8'd127, 25'h0C00000, 3'b000, 32'hBFC00000, 1'b0, 2},
      '{1'b0, 8'd130, 25'h0400000, 3'b000, 32'h40800000, 1'b0, 3},
      '{1'b0, 8'd127, 25'h0400000, 3'b100, 32'h3F000001, 1'b0, 3},
      '{1'b0, 8'd254, 25'h0FFFFFF, 3'b110, 32'h7F800000, 1'b1, 2},
      '{1'b0, 8'd127, 25'h1000003, 3'b000, 32'h40000002, 1'b0, 2},
      '{1'b0, 8'd127, 25'h1000001, 3'b001, 32'h40000001, 1'b0, 2}
    };
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive_op(tbl[i]);
      wait_result(found, res, ovf, lat);
      e = sb.pop_front();
      n_vec++;
      if (!found) begin
        n_err++;
        $display("FAIL vec%0d_timeout: no out_valid within 100 cycles", i);
      end else begin
        if (res !== e.res) begin
          n_err++;
          $display("FAIL vec%0d_result: got %h, want %h", i, res, e.res);
        end
        n_vec++;
        if (ovf !== e.ovf) begin
          n_err++;
          $display("FAIL vec%0d_overflow: got %b, want %b", i, ovf, e.ovf);
        end
        n_vec++;
        if (lat != e.lat) begin
          n_err++;
          $display("FAIL vec%0d_latency: got %0d, want %0d", i, lat, e.lat);
        end
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL vec%0d_retire: in_ready=%b out_valid=%b, want 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic        found, ovf;
    logic [31:0] res, held;
    int          lat;
    exp_t        e;
    out_ready = 1'b0;
    drive_op(tbl[0]);
    wait_result(found, held, ovf, lat);
    e = sb.pop_front();
    n_vec++;
    if (!found || held !== e.res) begin
      n_err++;
      $display("FAIL bp_first_result: found=%b got %h, want %h", found, held, e.res);
    end
    // Offer the next beat while the output is stalled; it must wait.
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = tbl[7].sign;
    in_exp   = tbl[7].e;
    in_sum   = tbl[7].sum;
    in_grs   = tbl[7].grs;
    sb.push_back('{tbl[7].res, tbl[7].ovf, tbl[7].lat});
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_result !== held || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d: valid=%b result=%h in_ready=%b, want 1/%h/0", c, out_valid, out_result, in_ready, held);
      end
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_accept: in_ready=%b, want 0", in_ready);
    end
    wait_result(found, res, ovf, lat);
    e = sb.pop_front();
    n_vec++;
    if (!found || res !== e.res || lat != e.lat) begin
      n_err++;
      $display("FAIL bp_second: found=%b got %h lat %0d, want %h lat %0d", found, res, lat, e.res, e.lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_norm();
    logic        found, ovf;
    logic [31:0] res;
    int          lat;
    exp_t        e;
    out_ready = 1'b1;
    drive_op(tbl[1]);
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    sb.delete();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_abort: valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    end
    n_vec++;
    if (out_result !== 32'h0) begin
      n_err++;
      $display("FAIL rst_clear: result=%h, want 0", out_result);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    drive_op(tbl[0]);
    wait_result(found, res, ovf, lat);
    e = sb.pop_front();
    n_vec++;
    if (!found || res !== e.res || ovf !== e.ovf || lat != e.lat) begin
      n_err++;
      $display("FAIL rst_recover: found=%b got %h/%b lat %0d, want %h/%b lat %0d", found, res, ovf, lat, e.res, e.ovf, e.lat);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_norm();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
